// File: rtl/fll_pkg.sv
// Shared types and constants for the FLL numerically controlled oscillator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: controller state enum, data width, square-wave amplitude.
package fll_pkg;

    localparam int W = 32;

    // Square-wave amplitude; the negative level is its two's complement.
    localparam logic signed [W-1:0] AMP     = 32'sh3FFF_FFFF;
    localparam logic signed [W-1:0] AMP_NEG = -AMP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fll_lock_det.sv
// Lock detector: counts consecutive in-tolerance delta strobes.
// Latency: locked updates on the clock edge that samples the qualifying strobe.
// Backpressure: none; every strobe presented is consumed.
//
// Ports:
//   clk, reset  - clock and synchronous active-high clear
//   strobe      - delta-valid qualifier (already gated by the controller)
//   delta       - signed frequency error
//   locked      - high once LOCK_CNT consecutive strobes had |delta| <= LOCK_TOL
module fll_lock_det
    import fll_pkg::*;
#(
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                strobe,
    input  logic signed [W-1:0] delta,
    output logic                locked
);

    localparam int              CW      = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(LOCK_CNT);
    localparam logic [W:0]      TOL     = (W + 1)'(LOCK_TOL);

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic signed [W:0] dx;
    logic [W:0]        mag;
    logic              in_tol;

    // Magnitude is taken one bit wider so |-2^31| does not wrap back negative.
    always_comb begin
        dx      = {delta[W-1], delta};
        mag     = dx[W] ? $unsigned(-dx) : $unsigned(dx);
        in_tol  = (mag <= TOL);
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            locked <= 1'b0;
        end else if (strobe) begin
            if (in_tol) begin
                cnt    <= cnt_inc;
                locked <= (cnt_inc == CNT_MAX);
            end else begin
                cnt    <= '0;
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fll_nco.sv
// FLL-steered NCO: phase accumulator with saturating frequency-word correction.
// Latency: fcw, phase and signal_gen update on the edge sampling the input; visible next cycle.
// Backpressure: none; strobes outside RUN (or with start asserted) are dropped.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   clk_en        - phase-advance enable
//   enabel        - run/hold control; start - start/restart pulse
//   delta         - signed frequency error; valid_sub_en - delta-valid strobe
//   signal_gen    - registered square wave (+/-AMP, 0 in IDLE)
//   fcw           - current frequency control word
//   locked        - lock flag
// Build option: define FLL_NCO_LOCK_EN to include the lock detector; otherwise locked is 0.
module fll_nco
    import fll_pkg::*;
#(
    parameter logic [31:0] FCW_INIT   = 32'h0100_0000,
    parameter logic [31:0] FCW_MIN    = 32'h0000_1000,
    parameter logic [31:0] FCW_MAX    = 32'h4000_0000,
    parameter int          GAIN_SHIFT = 4,
    parameter int          LOCK_TOL   = 2,
    parameter int          LOCK_CNT   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                enabel,
    input  logic                start,
    input  logic signed [W-1:0] delta,
    input  logic                valid_sub_en,
    output logic signed [W-1:0] signal_gen,
    output logic [W-1:0]        fcw,
    output logic                locked
);

    // Reject configurations the datapath cannot represent.
    if (GAIN_SHIFT < 0 || GAIN_SHIFT > W - 1) begin : g_bad_gain
        $error("fll_nco: GAIN_SHIFT out of range");
    end
    if (LOCK_CNT < 1 || LOCK_TOL < 0) begin : g_bad_lock
        $error("fll_nco: LOCK_CNT must be >= 1 and LOCK_TOL >= 0");
    end

    state_t              state;
    logic [W-1:0]        phase;
    logic [W-1:0]        phase_adv;
    logic signed [W-1:0] step;
    logic signed [W+1:0] step_ext;
    logic signed [W+1:0] sum;
    logic [W-1:0]        fcw_sat;

    always_comb begin
        // Phase advance always uses the fcw currently held, so a coincident
        // correction only affects the following advance.
        phase_adv = phase + fcw;

        // Two guard bits: fcw (unsigned, <2^32) plus a shifted delta can never
        // overflow a 34-bit signed sum, so extremes clamp instead of wrapping.
        step     = delta >>> GAIN_SHIFT;
        step_ext = {{2{step[W-1]}}, step};
        sum      = $signed({2'b00, fcw}) + step_ext;

        if (sum < $signed({2'b00, FCW_MIN})) begin
            fcw_sat = FCW_MIN;
        end else if (sum > $signed({2'b00, FCW_MAX})) begin
            fcw_sat = FCW_MAX;
        end else begin
            fcw_sat = sum[W-1:0];
        end
    end

    // Controller. Priority: reset > start > enabel > strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            fcw        <= FCW_INIT;
            signal_gen <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && enabel) begin
                        state      <= RUN;
                        phase      <= '0;
                        fcw        <= FCW_INIT;
                        signal_gen <= AMP;
                    end
                end

                RUN, HOLD: begin
                    if (start) begin
                        phase <= '0;
                        if (enabel) begin
                            state      <= RUN;
                            fcw        <= FCW_INIT;
                            signal_gen <= AMP;
                        end else begin
                            state      <= IDLE;
                            signal_gen <= '0;
                        end
                    end else if (state == HOLD) begin
                        // Everything stays frozen; only the resume is honoured.
                        if (enabel) begin
                            state <= RUN;
                        end
                    end else if (!enabel) begin
                        // The cycle that drops enabel already freezes the datapath.
                        state <= HOLD;
                    end else begin
                        if (clk_en) begin
                            phase      <= phase_adv;
                            signal_gen <= phase_adv[W-1] ? AMP_NEG : AMP;
                        end
                        if (valid_sub_en) begin
                            fcw <= fcw_sat;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    phase      <= '0;
                    signal_gen <= '0;
                end
            endcase
        end
    end

`ifdef FLL_NCO_LOCK_EN
    logic lock_strobe;
    logic lock_clr;

    // Same qualification as the fcw update, so HOLD/IDLE strobes are ignored.
    assign lock_strobe = (state == RUN) && enabel && !start && valid_sub_en;
    // Any start either restarts or returns to IDLE; both begin a fresh lock search.
    assign lock_clr    = reset || start;

    fll_lock_det #(
        .LOCK_TOL (LOCK_TOL),
        .LOCK_CNT (LOCK_CNT)
    ) u_lock_det (
        .clk    (clk),
        .reset  (lock_clr),
        .strobe (lock_strobe),
        .delta  (delta),
        .locked (locked)
    );
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_fll_nco.sv
// Scoreboard bench for fll_nco: stimulus pushes model expectations, a monitor pops
// and compares every cycle. Directed phases cover reset, the 256-cycle square wave,
// gain step, saturation, lock, hold and mid-run reset; a randomized phase follows.
module tb_fll_nco;

    localparam longint FCW_INIT   = 64'h0100_0000;
    localparam longint FCW_MIN    = 64'h0000_1000;
    localparam longint FCW_MAX    = 64'h4000_0000;
    localparam longint DIV        = 16;          // 2^GAIN_SHIFT
    localparam longint LOCK_TOL   = 2;
    localparam int     LOCK_CNT   = 8;
    localparam longint TWO32      = 64'h1_0000_0000;
    localparam longint HALF       = 64'h8000_0000;
    localparam longint AMPL       = 64'h3FFF_FFFF;
`ifdef FLL_NCO_LOCK_EN
    localparam bit     LOCK_EN    = 1'b1;
`else
    localparam bit     LOCK_EN    = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic                clk_en;
    logic                enabel;
    logic                start;
    logic signed [31:0]  delta;
    logic                valid_sub_en;
    logic signed [31:0]  signal_gen;
    logic [31:0]         fcw;
    logic                locked;

    fll_nco dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .enabel       (enabel),
        .start        (start),
        .delta        (delta),
        .valid_sub_en (valid_sub_en),
        .signal_gen   (signal_gen),
        .fcw          (fcw),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] sg;
        logic [31:0]        f;
        logic               lk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: 0 = stopped, 1 = running, 2 = frozen.
    int     m_mode   = 0;
    longint m_ph     = 0;
    longint m_f      = FCW_INIT;
    int     m_streak = 0;

    function automatic longint floor_div(longint d);
        longint r;
        r = d / DIV;
        if (d < 0 && (d % DIV) != 0) r = r - 1;
        return r;
    endfunction

    function automatic void model(bit r, bit s, bit en, bit ce, bit v, longint d);
        exp_t   e;
        longint mag;
        if (r) begin
            m_mode = 0; m_ph = 0; m_f = FCW_INIT; m_streak = 0;
        end else if (m_mode == 0) begin
            if (s && en) begin
                m_mode = 1; m_ph = 0; m_f = FCW_INIT; m_streak = 0;
            end
        end else if (s) begin
            m_ph = 0; m_streak = 0;
            if (en) begin
                m_mode = 1; m_f = FCW_INIT;
            end else begin
                m_mode = 0;
            end
        end else if (m_mode == 2) begin
            if (en) m_mode = 1;
        end else if (!en) begin
            m_mode = 2;
        end else begin
            if (ce) m_ph = (m_ph + m_f) % TWO32;
            if (v) begin
                m_f = m_f + floor_div(d);
                if (m_f < FCW_MIN) m_f = FCW_MIN;
                if (m_f > FCW_MAX) m_f = FCW_MAX;
                mag = (d < 0) ? -d : d;
                if (mag <= LOCK_TOL) m_streak = m_streak + 1;
                else m_streak = 0;
            end
        end
        if (m_mode == 0) e.sg = 32'sd0;
        else e.sg = (m_ph >= HALF) ? 32'(-AMPL) : 32'(AMPL);
        e.f  = 32'(m_f);
        e.lk = LOCK_EN && (m_streak >= LOCK_CNT);
        q.push_back(e);
    endfunction

    task automatic step(input bit r, input bit s, input bit en, input bit ce,
                        input bit v, input logic signed [31:0] d);
        @(negedge clk);
        reset        = r;
        start        = s;
        enabel       = en;
        clk_en       = ce;
        valid_sub_en = v;
        delta        = d;
        model(r, s, en, ce, v, longint'(d));
    endtask

    // Monitor: one expectation per clock edge, checked 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (signal_gen !== e.sg) begin
                    bad++;
                    $display("FAIL signal_gen t=%0t got=%h want=%h", $time, signal_gen, e.sg);
                end
                total++;
                if (fcw !== e.f) begin
                    bad++;
                    $display("FAIL fcw t=%0t got=%h want=%h", $time, fcw, e.f);
                end
                total++;
                if (locked !== e.lk) begin
                    bad++;
                    $display("FAIL locked t=%0t got=%b want=%b", $time, locked, e.lk);
                end
            end
        end
    end

    initial begin
        int r_rst, r_st, r_en, r_ce, r_v;
        logic signed [31:0] d;

        reset = 1'b1; start = 1'b0; enabel = 1'b0; clk_en = 1'b0;
        valid_sub_en = 1'b0; delta = '0;

        // Reset with noisy inputs, then idle with strobes (ignored).
        step(1, 1, 1, 1, 1, 32'sd100);
        step(1, 0, 0, 0, 0, 32'sd0);
        step(0, 0, 1, 1, 1, 32'sd500);
        step(0, 1, 0, 1, 0, 32'sd0);

        // Start and free-run: two full 256-cycle periods plus margin.
        step(0, 1, 1, 1, 0, 32'sd0);
        repeat (530) step(0, 0, 1, 1, 0, 32'sd0);

        // Gain step: +160 >>> 4 = +10.
        step(0, 0, 1, 1, 1, 32'sd160);
        repeat (3) step(0, 0, 1, 1, 0, 32'sd0);

        // Drive to the floor and push past it with the most negative delta.
        repeat (4) step(0, 0, 1, 1, 1, 32'sh8000_0000);
        repeat (2) step(0, 0, 1, 0, 0, 32'sd0);
        // Drive to the ceiling and push past it with the most positive delta.
        repeat (12) step(0, 0, 1, 1, 1, 32'sh7FFF_FFFF);
        repeat (2) step(0, 0, 1, 1, 0, 32'sd0);

        // Lock acquisition then loss.
        repeat (8) step(0, 0, 1, 1, 1, 32'sd1);
        step(0, 0, 1, 1, 0, 32'sd0);
        step(0, 0, 1, 1, 1, 32'sd5);
        step(0, 0, 1, 1, 0, 32'sd0);

        // Restart to nominal, re-lock, then hold for 50 cycles with strobes.
        step(0, 1, 1, 1, 0, 32'sd0);
        repeat (40) step(0, 0, 1, 1, 0, 32'sd0);
        repeat (9) step(0, 0, 1, 1, 1, -32'sd2);
        repeat (50) step(0, 0, 0, 1, 1, 32'sd4000);
        repeat (20) step(0, 0, 1, 1, 0, 32'sd0);

        // Reset in the middle of a run, then start-with-enabel-low back to idle.
        step(0, 0, 1, 1, 1, 32'sd320);
        step(1, 0, 1, 1, 1, 32'sd320);
        step(0, 0, 1, 1, 0, 32'sd0);
        step(0, 1, 1, 1, 0, 32'sd0);
        repeat (10) step(0, 0, 1, 1, 0, 32'sd0);
        step(0, 1, 0, 1, 0, 32'sd0);
        repeat (3) step(0, 0, 1, 1, 1, 32'sd7);

        // Randomized traffic.
        step(0, 1, 1, 1, 0, 32'sd0);
        for (int i = 0; i < 3000; i++) begin
            r_rst = $urandom_range(0, 299);
            r_st  = $urandom_range(0, 119);
            r_en  = $urandom_range(0, 19);
            r_ce  = $urandom_range(0, 3);
            r_v   = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0, 1:    d = 32'($signed($urandom_range(0, 8))) - 32'sd4;
                2:       d = 32'($signed($urandom_range(0, 4000))) - 32'sd2000;
                default: d = $signed($urandom);
            endcase
            step(r_rst == 0, r_st == 0, r_en != 0, r_ce != 0, r_v == 0, d);
        end

        // Drain the scoreboard with a bounded wait.
        @(negedge clk);
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
